// File: rtl/patch_fetch_pkg.sv
// Shared types and helpers for the patch fetch engine.
package patch_fetch_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

   // Window element address; wraps modulo 2^addr_w with no range check.
   function automatic int unsigned elem_addr(input int unsigned base, input int unsigned r,
                                             input int unsigned c, input int unsigned img_w,
                                             input int unsigned addr_w);
      int unsigned mask;
      mask = (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_w) - 32'd1);
      return (base + r * img_w + c) & mask;
   endfunction

endpackage

// File: rtl/patch_fetch_engine_rd_tag_pipe.sv
// Per-lane {valid, element index} delay line matching the RAM read latency.
module rd_tag_pipe #(
   parameter int unsigned MEM_LAT = 1,
   parameter int unsigned N_PORTS = 2,
   parameter int unsigned IDX_W   = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [N_PORTS-1:0]              vld_i,
   input  logic [N_PORTS-1:0][IDX_W-1:0]   idx_i,
   output logic [N_PORTS-1:0]              vld_o,
   output logic [N_PORTS-1:0][IDX_W-1:0]   idx_o
);

   if (MEM_LAT == 0) begin : g_pass
      // Combinational RAM: tag lines up with the issue register directly.
      assign vld_o = vld_i;
      assign idx_o = idx_i;
   end else begin : g_pipe
      logic [MEM_LAT-1:0][N_PORTS-1:0]            vld_q, vld_d;
      logic [MEM_LAT-1:0][N_PORTS-1:0][IDX_W-1:0] idx_q, idx_d;

      // Shift every stage by one.
      always_comb begin
         vld_d    = vld_q;
         idx_d    = idx_q;
         vld_d[0] = vld_i;
         idx_d[0] = idx_i;
         for (int unsigned s = 1; s < MEM_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            idx_d[s] = idx_q[s-1];
         end
      end

      // Stage registers; clearing them discards anything in flight.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            vld_q <= '0;
            idx_q <= '0;
         end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
         end
      end

      assign vld_o = vld_q[MEM_LAT-1];
      assign idx_o = idx_q[MEM_LAT-1];
   end

endmodule

// File: rtl/patch_fetch_engine.sv
// K x K patch fetcher: issues RAM reads for a window and assembles the patch.
module patch_fetch_engine
   import patch_fetch_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned K       = 3,
   parameter int unsigned IMG_W   = 28,
   parameter int unsigned N_PORTS = 2,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      slide,
   input  logic [ADDR_W-1:0]         base_addr,
   output logic [N_PORTS-1:0]        rd_en,
   output logic [N_PORTS*ADDR_W-1:0] rd_addr,
   input  logic [N_PORTS*DATA_W-1:0] rd_data,
   output logic [K*K*DATA_W-1:0]     patch,
   output logic                      busy,
   output logic                      done
);

   localparam int unsigned NumElem     = K * K;
   localparam int unsigned IdxW        = $clog2(NumElem);
   localparam int unsigned NumGrpFull  = ceil_div(NumElem, N_PORTS);
   localparam int unsigned NumGrpSlide = ceil_div(K, N_PORTS);
   localparam int unsigned GrpW        = $clog2(NumGrpFull + 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumElem - 1);

   state_e                           state_q, state_d;
   logic [ADDR_W-1:0]                base_q, base_d;
   logic [IdxW-1:0]                  row_q, row_d, col_q, col_d;
   logic [GrpW-1:0]                  grp_q, grp_d, grp_last_q, grp_last_d;
   logic                             valid_q, valid_d;
   logic                             done_q, done_d;
   logic [N_PORTS-1:0]               rd_en_q, rd_en_d;
   logic [N_PORTS-1:0][ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [N_PORTS-1:0][IdxW-1:0]     tag_idx_q, tag_idx_d;
   logic [NumElem-1:0][DATA_W-1:0]   patch_q, patch_d;

   logic [N_PORTS-1:0]               ret_vld;
   logic [N_PORTS-1:0][IdxW-1:0]     ret_idx;
   logic                             accept;
   logic                             slide_eff;
   logic                             last_retire;

   assign accept    = (state_q == IDLE) && start;
   // A slide without a held patch degrades to a full load.
   assign slide_eff = slide && valid_q;

   rd_tag_pipe #(
      .MEM_LAT (MEM_LAT),
      .N_PORTS (N_PORTS),
      .IDX_W   (IdxW)
   ) u_tag_pipe (
      .clk_i  (clk),
      .rst_ni (rst),
      .vld_i  (rd_en_q),
      .idx_i  (tag_idx_q),
      .vld_o  (ret_vld),
      .idx_o  (ret_idx)
   );

   // The last list element is always K*K-1, so its retirement ends the drain.
   always_comb begin
      last_retire = 1'b0;
      for (int unsigned j = 0; j < N_PORTS; j++) begin
         if (ret_vld[j] && (ret_idx[j] == LastIdx)) last_retire = 1'b1;
      end
   end

   // FSM next state and read-group generation.
   always_comb begin
      int unsigned r;
      int unsigned c;
      state_d    = state_q;
      base_d     = base_q;
      row_d      = row_q;
      col_d      = col_q;
      grp_d      = grp_q;
      grp_last_d = grp_last_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
      rd_en_d    = '0;
      rd_addr_d  = '0;
      tag_idx_d  = '0;
      r          = 32'(row_q);
      c          = 32'(col_q);
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               base_d  = base_addr;
               grp_d   = '0;
               col_d   = '0;
               if (slide_eff) begin
                  row_d      = IdxW'(K - 1);
                  grp_last_d = GrpW'(NumGrpSlide - 1);
               end else begin
                  row_d      = '0;
                  grp_last_d = GrpW'(NumGrpFull - 1);
               end
            end
         end
         ISSUE: begin
            // Lanes walk the list in order; lanes past the end stay idle with addr 0.
            for (int unsigned j = 0; j < N_PORTS; j++) begin
               if (r < K) begin
                  rd_en_d[j]   = 1'b1;
                  rd_addr_d[j] = ADDR_W'(elem_addr(32'(base_q), r, c, IMG_W, ADDR_W));
                  tag_idx_d[j] = IdxW'(r * K + c);
                  if (c == K - 1) begin
                     c = 0;
                     r = r + 1;
                  end else begin
                     c = c + 1;
                  end
               end
            end
            row_d = IdxW'(r);
            col_d = IdxW'(c);
            grp_d = grp_q + 1'b1;
            if (grp_q == grp_last_q) state_d = DRAIN;
         end
         DRAIN: begin
            if (last_retire) begin
               state_d = IDLE;
               done_d  = 1'b1;
               valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Patch update: row shift on a slide accept, then returned-data capture.
   always_comb begin
      patch_d = patch_q;
      if (accept && slide_eff) begin
         for (int unsigned i = 0; i < NumElem - K; i++) patch_d[i] = patch_q[i + K];
      end
      for (int unsigned j = 0; j < N_PORTS; j++) begin
         if (ret_vld[j]) patch_d[ret_idx[j]] = rd_data[j*DATA_W +: DATA_W];
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         grp_q      <= '0;
         grp_last_q <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= '0;
         rd_addr_q  <= '0;
         tag_idx_q  <= '0;
         patch_q    <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         row_q      <= row_d;
         col_q      <= col_d;
         grp_q      <= grp_d;
         grp_last_q <= grp_last_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         tag_idx_q  <= tag_idx_d;
         patch_q    <= patch_d;
      end
   end

   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign patch   = patch_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;

endmodule

// File: tb/tb_patch_fetch_engine.sv
// Scoreboard bench: three engine configurations against behavioural RAMs.
module tb_patch_fetch_engine;

   typedef struct {
      int          d;
      logic [71:0] p;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       start_v [3];
   logic       slide_v [3];
   logic [9:0] base_v  [3];

   logic [1:0]  rd_en_a;
   logic [19:0] rd_addr_a;
   logic [15:0] rd_data_a;
   logic [0:0]  rd_en_b;
   logic [9:0]  rd_addr_b;
   logic [7:0]  rd_data_b;
   logic [3:0]  rd_en_c;
   logic [39:0] rd_addr_c;
   logic [31:0] rd_data_c;

   logic [71:0] patch_v [3];
   logic        busy_v  [3];
   logic        done_v  [3];
   logic [3:0]  rd_en_v [3];

   assign rd_en_v[0] = {2'b00, rd_en_a};
   assign rd_en_v[1] = {3'b000, rd_en_b};
   assign rd_en_v[2] = rd_en_c;

   patch_fetch_engine u_dut_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .slide(slide_v[0]), .base_addr(base_v[0]),
      .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .patch(patch_v[0]),
      .busy(busy_v[0]), .done(done_v[0])
   );

   patch_fetch_engine #(.N_PORTS(1), .MEM_LAT(0)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .slide(slide_v[1]), .base_addr(base_v[1]),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .patch(patch_v[1]),
      .busy(busy_v[1]), .done(done_v[1])
   );

   patch_fetch_engine #(.N_PORTS(4), .MEM_LAT(3)) u_dut_c (
      .clk(clk), .rst(rst), .start(start_v[2]), .slide(slide_v[2]), .base_addr(base_v[2]),
      .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .patch(patch_v[2]),
      .busy(busy_v[2]), .done(done_v[2])
   );

   // RAMs: word = low byte of its address.
   always @(posedge clk) begin
      for (int j = 0; j < 2; j++) rd_data_a[j*8 +: 8] <= rd_addr_a[j*10 +: 8];
   end
   assign rd_data_b = rd_addr_b[7:0];
   logic [31:0] c_p1, c_p2, c_p3;
   always @(posedge clk) begin
      for (int j = 0; j < 4; j++) c_p1[j*8 +: 8] <= rd_addr_c[j*10 +: 8];
      c_p2 <= c_p1;
      c_p3 <= c_p2;
   end
   assign rd_data_c = c_p3;

   int n_vec = 0;
   int n_err = 0;

   function automatic void check(input string tag, input logic [71:0] obs,
                                 input logic [71:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endfunction

   // Read counters per DUT, sampled mid-cycle.
   int rd_cnt [3] = '{0, 0, 0};
   always @(negedge clk) begin
      rd_cnt[0] <= rd_cnt[0] + $countones(rd_en_a);
      rd_cnt[1] <= rd_cnt[1] + $countones(rd_en_b);
      rd_cnt[2] <= rd_cnt[2] + $countones(rd_en_c);
   end

   // Reference model and scoreboard.
   logic [71:0] mdl       [3];
   logic        mdl_valid [3];
   exp_t        sb [$];
   exp_t        mon_e;

   function automatic logic [7:0] word_at(input logic [9:0] b, input int r, input int c);
      logic [9:0] a;
      a = b + 10'(r * 28 + c);
      return a[7:0];
   endfunction

   function automatic void push_exp(input int d, input logic sl, input logic [9:0] b);
      logic [71:0] p;
      exp_t        e;
      if (sl && mdl_valid[d]) begin
         p = mdl[d];
         p[47:0] = mdl[d][71:24];
         for (int c = 0; c < 3; c++) p[(6 + c)*8 +: 8] = word_at(b, 2, c);
      end else begin
         for (int i = 0; i < 9; i++) p[i*8 +: 8] = word_at(b, i / 3, i % 3);
      end
      mdl[d]       = p;
      mdl_valid[d] = 1'b1;
      e.d = d;
      e.p = p;
      sb.push_back(e);
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 3; d++) begin
         mdl[d]       = '0;
         mdl_valid[d] = 1'b0;
      end
   endfunction

   // Compare the patch whenever any DUT signals done.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (done_v[d] === 1'b1) begin
            if (sb.size() == 0) begin
               check("sb_depth", 72'(sb.size()), 72'd1);
            end else begin
               mon_e = sb.pop_front();
               check("sb_dut", 72'(d), 72'(mon_e.d));
               check("patch", patch_v[d], mon_e.p);
            end
         end
      end
   end

   logic [3:0] hist_en [64];
   logic [9:0] hist_a1 [64];

   task automatic run_op(input int d, input logic sl, input logic [9:0] b,
                         input int exp_edges, input int exp_reads);
      int n;
      int r0;
      push_exp(d, sl, b);
      r0 = rd_cnt[d];
      @(negedge clk);
      start_v[d] = 1'b1;
      slide_v[d] = sl;
      base_v[d]  = b;
      @(posedge clk);
      #1;
      start_v[d] = 1'b0;
      slide_v[d] = 1'b0;
      check("busy_on", 72'(busy_v[d]), 72'd1);
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         n++;
         #1;
         hist_en[n] = rd_en_v[d];
         hist_a1[n] = rd_addr_a[19:10];
         if (done_v[d]) break;
      end
      check("done_edge", 72'(n), 72'(exp_edges));
      check("busy_off", 72'(busy_v[d]), 72'd0);
      @(negedge clk);
      #1;
      check("reads", 72'(rd_cnt[d] - r0), 72'(exp_reads));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int         n;
      int         r0;
      logic [71:0] late_or;
      for (int d = 0; d < 3; d++) begin
         start_v[d] = 1'b0;
         slide_v[d] = 1'b0;
         base_v[d]  = '0;
      end
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_rd_en", 72'(rd_en_a), 72'd0);
      check("rst_rd_addr", 72'(rd_addr_a), 72'd0);
      check("rst_patch", patch_v[0], 72'd0);
      check("rst_busy", 72'(busy_v[0]), 72'd0);
      check("rst_done", 72'(done_v[0]), 72'd0);

      // Slide before any valid patch behaves as a full load.
      run_op(0, 1'b1, 10'd100, 7, 9);

      // Full load at 30; lane 1 idle in the last group.
      run_op(0, 1'b0, 10'd30, 7, 9);
      check("g0_lane1_addr", 72'(hist_a1[1]), 72'd31);
      check("g4_rd_en", 72'(hist_en[5]), 72'd1);
      check("g4_lane1_addr", 72'(hist_a1[5]), 72'd0);

      // Row slide reuses rows 1..2.
      run_op(0, 1'b1, 10'd58, 4, 3);

      // start pulsed while busy is ignored.
      fork
         run_op(0, 1'b0, 10'd200, 7, 9);
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            start_v[0] = 1'b1;
            base_v[0]  = 10'd77;
            @(negedge clk);
            start_v[0] = 1'b0;
         end
      join
      repeat (6) @(posedge clk);
      #1;
      check("pulse_idle", 72'(busy_v[0]), 72'd0);

      // start held through done: back-to-back operations.
      push_exp(0, 1'b0, 10'd300);
      push_exp(0, 1'b0, 10'd300);
      r0 = rd_cnt[0];
      @(negedge clk);
      start_v[0] = 1'b1;
      slide_v[0] = 1'b0;
      base_v[0]  = 10'd300;
      @(posedge clk);
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         n++;
         #1;
         if (done_v[0]) break;
      end
      check("hold_done1", 72'(n), 72'd7);
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      check("hold_busy", 72'(busy_v[0]), 72'd1);
      check("hold_en_wait", 72'(rd_en_v[0]), 72'd0);
      @(posedge clk);
      #1;
      check("hold_en", 72'(rd_en_v[0]), 72'd3);
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         n++;
         #1;
         if (done_v[0]) break;
      end
      check("hold_done2", 72'(n), 72'd6);
      @(negedge clk);
      #1;
      check("hold_reads", 72'(rd_cnt[0] - r0), 72'd18);

      // Reset asserted during ISSUE.
      @(negedge clk);
      start_v[0] = 1'b1;
      base_v[0]  = 10'd500;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      #1;
      check("mid_rst_rd_en", 72'(rd_en_a), 72'd0);
      check("mid_rst_rd_addr", 72'(rd_addr_a), 72'd0);
      check("mid_rst_busy", 72'(busy_v[0]), 72'd0);
      check("mid_rst_patch", patch_v[0], 72'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      late_or = '0;
      repeat (5) begin
         @(posedge clk);
         #1;
         late_or = late_or | patch_v[0];
      end
      check("late_data", late_or, 72'd0);

      // Full load with address wrap.
      run_op(0, 1'b0, 10'd1020, 7, 9);
      check("wrap_e8", 72'(patch_v[0][71:64]), 72'd54);

      // Single-port combinational RAM.
      run_op(1, 1'b0, 10'd30, 10, 9);
      run_op(1, 1'b1, 10'd58, 4, 3);

      // Four ports, three-cycle RAM.
      run_op(2, 1'b0, 10'd30, 7, 9);
      run_op(2, 1'b1, 10'd58, 5, 3);

      repeat (4) @(posedge clk);
      #1;
      check("sb_left", 72'(sb.size()), 72'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
